cpu_rst_seq: RTL and testbench
==============================

# cpu_rst_seq

Parametrised reset sequencer and run-budget controller for the Citrus CPU and its peripheral domains. On a start request it holds every domain in reset for a programmable interval. It then releases NCH active-low domain resets one at a time, lets the system run for a bounded number of cycles, and finally re-asserts all resets. It sits between the top-level clock/reset source and the `clrn` inputs of `cpuctr` and its sibling blocks. It replaces the hand-written reset pulses used in simulation benches with a synthesizable, cycle-exact sequence.

## Interface
Parameters:
- NCH, 4: number of reset domains (≥1); channel 0 is the CPU core.
- HOLD, 8: cycles all domains stay in reset after start (≥1).
- STAGGER, 4: cycles between consecutive channel releases (0 = all release together).
- RUN_W, 16: width of the run budget and cycle counter (2..32).

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a sequence; honoured only in IDLE.
- stop  in  1  abort request; honoured in any non-IDLE state.
- run_budget  in  RUN_W  run length in cycles; latched on an accepted start; 0 = unlimited.
- clrn_out  out  NCH  per-domain active-low reset (0 = domain held in reset).
- busy  out  1  high in HOLD, RELEASE and RUN.
- done  out  1  one-cycle pulse when a sequence ends, whether by budget or by stop.
- aborted  out  1  set together with done when the end was caused by stop; held until the next accepted start.
- cycles  out  RUN_W  RUN-state cycle count; holds its final value until the next accepted start.

## Operation
- States: IDLE, HOLD, RELEASE, RUN.
- IDLE: clrn_out = all 0, busy = 0.
  - If start = 1 and stop = 0: latch run_budget, clear cycles and aborted, load the hold counter, go to HOLD.
- HOLD: count HOLD cycles, then go to RELEASE.
  - clrn_out[0] rises on the same edge that leaves HOLD.
  - If NCH = 1 or STAGGER = 0, all remaining channels rise on that edge too, and the FSM goes directly to RUN.
- RELEASE: every STAGGER cycles, set the next clrn_out bit in ascending index order.
  - The edge that sets clrn_out[NCH-1] also enters RUN with cycles = 0.
  - Channels never release out of order, and a released channel never re-asserts except at sequence end.
- RUN: cycles increments by 1 every edge.
  - On the edge where cycles becomes the latched budget (budget ≠ 0): clrn_out = all 0, done = 1, go to IDLE.
  - Budget 0: the counter saturates at all-ones and only stop ends RUN.
- stop in HOLD, RELEASE or RUN: next edge sets clrn_out = all 0, done = 1, aborted = 1, go to IDLE. cycles freezes.
- start while busy is ignored.
- start and stop in the same IDLE cycle: stop wins, nothing happens.
- stop in IDLE has no effect.
- The budget and exit compare are unsigned RUN_W-bit values. A run_budget input change after acceptance has no effect.

## Timing
- Reset values: state IDLE, clrn_out = 0, busy = 0, done = 0, aborted = 0, cycles = 0.
- rst mid-sequence forces the reset values on the next edge and overrides start and stop. No done pulse is produced.
- Start accepted at edge k:
  - busy = 1 from edge k.
  - clrn_out[i] rises at edge k + HOLD + i·STAGGER.
  - RUN begins at edge R = k + HOLD + (NCH−1)·STAGGER.
  - Sequence ends at edge R + budget: clrn_out falls, done = 1, busy = 0, on that same edge.
- done is high for exactly one cycle.
- A new start can be accepted in the cycle that done is high, since the FSM is already in IDLE.
- stop sampled at edge s ends the sequence at edge s. Outputs change after that edge, so the latency is 1 cycle from the stop assertion.

## Test plan
- NCH=4, HOLD=8, STAGGER=4, budget=50, start at edge 10:
  - clrn_out bits rise at edges 18, 22, 26, 30.
  - cycles reaches 50 at edge 80, where clrn_out = 0000, done pulses, aborted = 0.
- Same config, stop asserted so it is sampled at edge 40:
  - At edge 40: clrn_out = 0000, done = 1, aborted = 1, cycles = 10 (frozen).
  - A start at edge 45 clears aborted and cycles.
- STAGGER=0, NCH=4, budget=5, start at edge 2: clrn_out = 1111 at edge 10, done at edge 15.
- budget=0 with RUN_W=4:
  - cycles saturates at 15 and the block remains busy.
  - stop at edge 100 ends the sequence with aborted = 1.
- rst asserted at edge 24 during RELEASE:
  - Next edge gives clrn_out = 0000, busy = 0, no done pulse.
  - A start pulse during busy, and start+stop together in IDLE, are both ignored.
- Back-to-back: start in the done cycle begins a new HOLD with cycles reset to 0. Release timing matches the first run.

Source files
------------

// File: rtl/cpu_rst_seq.sv
// Reset sequencer for the CPU and its peripheral domains. It holds every domain in
// reset, releases the domains one by one in index order, then runs for a bounded budget.
module cpu_rst_seq #(
  parameter int NCH     = 4,
  parameter int HOLD    = 8,
  parameter int STAGGER = 4,
  parameter int RUN_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [RUN_W-1:0] run_budget,
  output logic [NCH-1:0]   clrn_out,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [RUN_W-1:0] cycles
);

  localparam int HOLD_W = $clog2(HOLD + 1);
  localparam int STG_W  = $clog2(STAGGER + 2);
  localparam int CH_W   = $clog2(NCH + 1);
  localparam bit ALL_AT_ONCE = (NCH == 1) || (STAGGER == 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_RELEASE,
    S_RUN
  } state_t;

  state_t             state_reg, state_next;
  logic [HOLD_W-1:0]  hold_cnt_reg, hold_cnt_next;
  logic [STG_W-1:0]   stag_cnt_reg, stag_cnt_next;
  logic [CH_W-1:0]    ch_reg, ch_next;
  logic [NCH-1:0]     clrn_reg, clrn_next;
  logic [RUN_W-1:0]   budget_reg, budget_next;
  logic [RUN_W-1:0]   cycles_reg, cycles_next;
  logic               done_reg, done_next;
  logic               aborted_reg, aborted_next;

  logic               release_all;
  logic               release_one;
  logic [CH_W-1:0]    release_idx;
  logic               clear_all;
  logic [RUN_W-1:0]   cycles_inc;

  // Saturating increment: an unlimited run parks at all-ones.
  assign cycles_inc = (cycles_reg == {RUN_W{1'b1}}) ? cycles_reg : cycles_reg + 1'b1;

  always_comb begin
    state_next    = state_reg;
    hold_cnt_next = hold_cnt_reg;
    stag_cnt_next = stag_cnt_reg;
    ch_next       = ch_reg;
    budget_next   = budget_reg;
    cycles_next   = cycles_reg;
    done_next     = 1'b0;
    aborted_next  = aborted_reg;
    release_all   = 1'b0;
    release_one   = 1'b0;
    release_idx   = ch_reg;
    clear_all     = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (start && !stop) begin
          budget_next   = run_budget;
          cycles_next   = '0;
          aborted_next  = 1'b0;
          hold_cnt_next = HOLD_W'(HOLD - 1);
          state_next    = S_HOLD;
        end
      end

      S_HOLD: begin
        if (stop) begin
          clear_all    = 1'b1;
          done_next    = 1'b1;
          aborted_next = 1'b1;
          state_next   = S_IDLE;
        end else if (hold_cnt_reg == '0) begin
          if (ALL_AT_ONCE) begin
            release_all = 1'b1;
            cycles_next = '0;
            state_next  = S_RUN;
          end else begin
            release_one   = 1'b1;
            release_idx   = '0;
            ch_next       = CH_W'(1);
            stag_cnt_next = STG_W'(STAGGER - 1);
            state_next    = S_RELEASE;
          end
        end else begin
          hold_cnt_next = hold_cnt_reg - 1'b1;
        end
      end

      S_RELEASE: begin
        if (stop) begin
          clear_all    = 1'b1;
          done_next    = 1'b1;
          aborted_next = 1'b1;
          state_next   = S_IDLE;
        end else if (stag_cnt_reg == '0) begin
          release_one = 1'b1;
          if (ch_reg == CH_W'(NCH - 1)) begin
            cycles_next = '0;
            state_next  = S_RUN;
          end else begin
            ch_next       = ch_reg + 1'b1;
            stag_cnt_next = STG_W'(STAGGER - 1);
          end
        end else begin
          stag_cnt_next = stag_cnt_reg - 1'b1;
        end
      end

      S_RUN: begin
        // The stop edge still counts, so the frozen value includes it.
        cycles_next = cycles_inc;
        if (stop) begin
          clear_all    = 1'b1;
          done_next    = 1'b1;
          aborted_next = 1'b1;
          state_next   = S_IDLE;
        end else if (budget_reg != '0 && cycles_inc == budget_reg) begin
          clear_all  = 1'b1;
          done_next  = 1'b1;
          state_next = S_IDLE;
        end
      end

      default: begin
        clear_all  = 1'b1;
        state_next = S_IDLE;
      end
    endcase
  end

  // Per-domain release bit: only the selected channel can rise, and all fall together.
  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
      assign clrn_next[gi] = clear_all ? 1'b0 :
                             (release_all || (release_one && release_idx == CH_W'(gi))) ? 1'b1 :
                             clrn_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      hold_cnt_reg <= '0;
      stag_cnt_reg <= '0;
      ch_reg       <= '0;
      clrn_reg     <= '0;
      budget_reg   <= '0;
      cycles_reg   <= '0;
      done_reg     <= 1'b0;
      aborted_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      hold_cnt_reg <= hold_cnt_next;
      stag_cnt_reg <= stag_cnt_next;
      ch_reg       <= ch_next;
      clrn_reg     <= clrn_next;
      budget_reg   <= budget_next;
      cycles_reg   <= cycles_next;
      done_reg     <= done_next;
      aborted_reg  <= aborted_next;
    end
  end

  assign clrn_out = clrn_reg;
  assign busy     = (state_reg != S_IDLE);
  assign done     = done_reg;
  assign aborted  = aborted_reg;
  assign cycles   = cycles_reg;

endmodule

// File: tb/tb_cpu_rst_seq.sv
// Directed bench for cpu_rst_seq: expected outputs are queued per edge and checked on the
// falling edge after that edge, across three configurations sharing one clock.
module tb_cpu_rst_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] run_budget = '0;
  logic [2:0]  start_v = '0;
  logic [2:0]  stop_v  = '0;

  logic [3:0]  clrn0, clrn1, clrn2;
  logic        busy0, busy1, busy2;
  logic        done0, done1, done2;
  logic        ab0, ab1, ab2;
  logic [15:0] cyc0, cyc1;
  logic [3:0]  cyc2;

  int edge_cnt = 0;
  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    int          e;
    int          id;
    string       tag;
    logic [22:0] val;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt = edge_cnt + 1;

  cpu_rst_seq #(.NCH(4), .HOLD(8), .STAGGER(4), .RUN_W(16)) dut0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .stop(stop_v[0]), .run_budget(run_budget),
    .clrn_out(clrn0), .busy(busy0), .done(done0), .aborted(ab0), .cycles(cyc0));

  cpu_rst_seq #(.NCH(4), .HOLD(8), .STAGGER(0), .RUN_W(16)) dut1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .stop(stop_v[1]), .run_budget(run_budget),
    .clrn_out(clrn1), .busy(busy1), .done(done1), .aborted(ab1), .cycles(cyc1));

  cpu_rst_seq #(.NCH(4), .HOLD(8), .STAGGER(4), .RUN_W(4)) dut2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .stop(stop_v[2]), .run_budget(run_budget[3:0]),
    .clrn_out(clrn2), .busy(busy2), .done(done2), .aborted(ab2), .cycles(cyc2));

  function automatic logic [22:0] pick(int id);
    case (id)
      0:       return {clrn0, busy0, done0, ab0, cyc0};
      1:       return {clrn1, busy1, done1, ab1, cyc1};
      default: return {clrn2, busy2, done2, ab2, 12'd0, cyc2};
    endcase
  endfunction

  task automatic sb_push(int e, int id, string tag, logic [3:0] c, logic b, logic d,
                         logic a, logic [15:0] cy);
    exp_t x;
    x.e   = e;
    x.id  = id;
    x.tag = tag;
    x.val = {c, b, d, a, cy};
    q.push_back(x);
  endtask

  // Comparison point: outputs after edge N are sampled on the following falling edge.
  always @(negedge clk) begin
    exp_t x;
    logic [22:0] obs;
    while (q.size() > 0 && q[0].e <= edge_cnt) begin
      x   = q.pop_front();
      obs = pick(x.id);
      n_assert++;
      assert (x.e == edge_cnt && obs === x.val)
        $display("edge %0d dut%0d %s: clrn/busy/done/ab/cycles = %h ok", edge_cnt, x.id, x.tag, obs);
      else begin
        n_fail++;
        $error("FAIL %s (dut%0d, due edge %0d, now %0d): observed %h required %h",
               x.tag, x.id, x.e, edge_cnt, obs, x.val);
      end
    end
  end

  task automatic wait_edge(int n);
    while (edge_cnt < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive start/stop so they are sampled at edge k only.
  task automatic pulse(int id, int k, logic s, logic p);
    wait_edge(k - 1);
    start_v[id] = s;
    stop_v[id]  = p;
    wait_edge(k);
    start_v[id] = 1'b0;
    stop_v[id]  = 1'b0;
  endtask

  initial begin
    // Full sequence with budget 50, start sampled at edge 10.
    sb_push(2,  0, "in_reset",   4'b0000, 0, 0, 0, 0);
    sb_push(9,  0, "idle",       4'b0000, 0, 0, 0, 0);
    sb_push(10, 0, "start_busy", 4'b0000, 1, 0, 0, 0);
    sb_push(17, 0, "hold_end",   4'b0000, 1, 0, 0, 0);
    sb_push(18, 0, "rel_ch0",    4'b0001, 1, 0, 0, 0);
    sb_push(21, 0, "gap_ch0",    4'b0001, 1, 0, 0, 0);
    sb_push(22, 0, "rel_ch1",    4'b0011, 1, 0, 0, 0);
    sb_push(26, 0, "rel_ch2",    4'b0111, 1, 0, 0, 0);
    sb_push(29, 0, "gap_ch2",    4'b0111, 1, 0, 0, 0);
    sb_push(30, 0, "run_enter",  4'b1111, 1, 0, 0, 0);
    sb_push(31, 0, "run_count",  4'b1111, 1, 0, 0, 1);
    sb_push(79, 0, "run_pre",    4'b1111, 1, 0, 0, 49);
    sb_push(80, 0, "budget_end", 4'b0000, 0, 1, 0, 50);
    sb_push(81, 0, "done_1cyc",  4'b0000, 0, 0, 0, 50);
    run_budget = 16'd50;
    wait_edge(3);
    rst = 1'b0;
    pulse(0, 10, 1'b1, 1'b0);
    wait_edge(12);
    run_budget = 16'd7;

    // Abort by stop in RUN, stop in IDLE, restart, abort in HOLD.
    wait_edge(100);
    run_budget = 16'd50;
    sb_push(110, 0, "b_start",    4'b0000, 1, 0, 0, 0);
    sb_push(139, 0, "b_run",      4'b1111, 1, 0, 0, 9);
    sb_push(140, 0, "stop_run",   4'b0000, 0, 1, 1, 10);
    sb_push(141, 0, "stop_after", 4'b0000, 0, 0, 1, 10);
    sb_push(142, 0, "stop_idle",  4'b0000, 0, 0, 1, 10);
    sb_push(144, 0, "ab_held",    4'b0000, 0, 0, 1, 10);
    sb_push(145, 0, "restart",    4'b0000, 1, 0, 0, 0);
    sb_push(150, 0, "stop_hold",  4'b0000, 0, 1, 1, 0);
    sb_push(151, 0, "stop_hold2", 4'b0000, 0, 0, 1, 0);
    pulse(0, 110, 1'b1, 1'b0);
    pulse(0, 140, 1'b0, 1'b1);
    pulse(0, 142, 1'b0, 1'b1);
    pulse(0, 145, 1'b1, 1'b0);
    pulse(0, 150, 1'b0, 1'b1);

    // Budget 3, then a new start in the done cycle.
    wait_edge(200);
    run_budget = 16'd3;
    sb_push(210, 0, "bb_start",  4'b0000, 1, 0, 0, 0);
    sb_push(230, 0, "bb_run",    4'b1111, 1, 0, 0, 0);
    sb_push(233, 0, "bb_done",   4'b0000, 0, 1, 0, 3);
    sb_push(234, 0, "bb_again",  4'b0000, 1, 0, 0, 0);
    sb_push(241, 0, "bb_hold",   4'b0000, 1, 0, 0, 0);
    sb_push(242, 0, "bb_ch0",    4'b0001, 1, 0, 0, 0);
    sb_push(246, 0, "bb_ch1",    4'b0011, 1, 0, 0, 0);
    sb_push(250, 0, "bb_ch2",    4'b0111, 1, 0, 0, 0);
    sb_push(254, 0, "bb_ch3",    4'b1111, 1, 0, 0, 0);
    sb_push(259, 0, "bb_run5",   4'b1111, 1, 0, 0, 5);
    sb_push(260, 0, "bb_stop",   4'b0000, 0, 1, 1, 6);
    pulse(0, 210, 1'b1, 1'b0);
    wait_edge(232);
    run_budget = 16'd50;
    pulse(0, 234, 1'b1, 1'b0);
    pulse(0, 260, 0, 1'b1);

    // Start while busy ignored, rst during RELEASE, start+stop in IDLE ignored.
    wait_edge(300);
    sb_push(318, 0, "r_ch0",      4'b0001, 1, 0, 0, 0);
    sb_push(322, 0, "r_ch1",      4'b0011, 1, 0, 0, 0);
    sb_push(323, 0, "r_pre",      4'b0011, 1, 0, 0, 0);
    sb_push(324, 0, "rst_mid",    4'b0000, 0, 0, 0, 0);
    sb_push(325, 0, "rst_nodone", 4'b0000, 0, 0, 0, 0);
    sb_push(330, 0, "start_stop", 4'b0000, 0, 0, 0, 0);
    sb_push(340, 0, "still_idle", 4'b0000, 0, 0, 0, 0);
    pulse(0, 310, 1'b1, 1'b0);
    pulse(0, 315, 1'b1, 1'b0);
    wait_edge(323);
    rst = 1'b1;
    wait_edge(324);
    rst = 1'b0;
    pulse(0, 330, 1'b1, 1'b1);

    // STAGGER = 0: every channel releases together.
    wait_edge(400);
    run_budget = 16'd5;
    sb_push(402, 1, "s0_start", 4'b0000, 1, 0, 0, 0);
    sb_push(409, 1, "s0_hold",  4'b0000, 1, 0, 0, 0);
    sb_push(410, 1, "s0_all",   4'b1111, 1, 0, 0, 0);
    sb_push(414, 1, "s0_run4",  4'b1111, 1, 0, 0, 4);
    sb_push(415, 1, "s0_done",  4'b0000, 0, 1, 0, 5);
    sb_push(416, 1, "s0_after", 4'b0000, 0, 0, 0, 5);
    pulse(1, 402, 1'b1, 1'b0);

    // Unlimited budget with a 4-bit counter: saturate, then stop.
    wait_edge(500);
    run_budget = 16'd0;
    sb_push(522, 2, "w4_run",   4'b1111, 1, 0, 0, 0);
    sb_push(530, 2, "w4_cnt8",  4'b1111, 1, 0, 0, 8);
    sb_push(537, 2, "w4_max",   4'b1111, 1, 0, 0, 15);
    sb_push(560, 2, "w4_sat",   4'b1111, 1, 0, 0, 15);
    sb_push(599, 2, "w4_pre",   4'b1111, 1, 0, 0, 15);
    sb_push(600, 2, "w4_stop",  4'b0000, 0, 1, 1, 15);
    sb_push(601, 2, "w4_after", 4'b0000, 0, 0, 1, 15);
    pulse(2, 502, 1'b1, 1'b0);
    pulse(2, 600, 1'b0, 1'b1);

    wait_edge(605);
    @(negedge clk);
    #1;
    n_assert++;
    assert (q.size() == 0)
    else begin
      n_fail++;
      $error("FAIL scoreboard_drain: observed %0d pending required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
